// File: rtl/toi2s_pkg.sv
// Shared types and constants for the I2S amplifier power-up/configuration path.
// Holds the init command table and the state encodings of the sequencer and I2C engine.
package toi2s_pkg;

  localparam int AMP_NCMD = 8;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } amp_cmd_t;

  // Entry 0 occupies the least-significant slot and is written first.
  localparam amp_cmd_t [AMP_NCMD-1:0] AMP_INIT_TABLE = {
    16'h0303,
    16'h5403,
    16'h4C30,
    16'h0200,
    16'h0100,
    16'h0302,
    16'h7F00,
    16'h0000
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN_WAIT,
    S_XFER,
    S_NEXT,
    S_RUN,
    S_ERROR
  } seq_state_t;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_BIT,
    B_ACK,
    B_STOP
  } bit_state_t;

  function automatic logic [7:0] addr_wr_byte(input logic [6:0] addr7);
    return {addr7, 1'b0};
  endfunction

endpackage

// File: rtl/amp_i2c_wr.sv
// Single 3-byte I2C write engine: START, {addr,W}, reg, data, STOP, paced by a quarter-period tick.
// Aborts to STOP after the ACK bit of any byte that the slave NACKs.
module amp_i2c_wr
  import toi2s_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       q_tick,
  input  logic       go,
  input  logic [6:0] addr7,
  input  logic [7:0] reg_addr,
  input  logic [7:0] data,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_oe,
  output logic       done,
  output logic       nack
);

  bit_state_t state, state_nxt;
  logic [1:0] q, q_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [1:0] byte_cnt, byte_nxt;
  logic [7:0] sh, sh_nxt;
  logic [7:0] next_byte;
  logic       scl_nxt, sda_oe_nxt;
  logic       nack_seen, nack_seen_nxt;

  // Byte loaded after the ACK of byte 0 is the register, after byte 1 the data.
  assign next_byte = (byte_cnt == 2'd0) ? reg_addr : data;

  // Every registered output is computed for the quarter that begins at the tick edge.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_nxt     = state;
    q_nxt         = q;
    bit_nxt       = bit_cnt;
    byte_nxt      = byte_cnt;
    sh_nxt        = sh;
    scl_nxt       = scl_o;
    sda_oe_nxt    = sda_oe;
    nack_seen_nxt = nack_seen;
    done          = 1'b0;
    if (go) begin
      state_nxt     = B_START;
      q_nxt         = 2'd0;
      bit_nxt       = 3'd0;
      byte_nxt      = 2'd0;
      sh_nxt        = addr_wr_byte(addr7);
      scl_nxt       = 1'b1;
      sda_oe_nxt    = 1'b1;
      nack_seen_nxt = 1'b0;
    end else if (q_tick) begin
      q_nxt = q + 2'd1;
      unique case (state)
        B_IDLE: q_nxt = q;
        B_START: begin
          if (q == 2'd0) begin
            scl_nxt = 1'b0;
          end else begin
            state_nxt  = B_BIT;
            q_nxt      = 2'd0;
            sda_oe_nxt = ~sh[7];
          end
        end
        B_BIT: begin
          unique case (q)
            2'd0: scl_nxt = 1'b1;
            2'd2: scl_nxt = 1'b0;
            2'd3: begin
              if (bit_cnt == 3'd7) begin
                state_nxt  = B_ACK;
                sda_oe_nxt = 1'b0;
              end else begin
                bit_nxt    = bit_cnt + 3'd1;
                sh_nxt     = {sh[6:0], 1'b0};
                sda_oe_nxt = ~sh[6];
              end
            end
            default: ;
          endcase
        end
        B_ACK: begin
          unique case (q)
            2'd0: scl_nxt = 1'b1;
            2'd2: begin
              scl_nxt       = 1'b0;
              nack_seen_nxt = sda_i;
            end
            2'd3: begin
              if (nack_seen || byte_cnt == 2'd2) begin
                state_nxt  = B_STOP;
                sda_oe_nxt = 1'b1;
              end else begin
                state_nxt  = B_BIT;
                byte_nxt   = byte_cnt + 2'd1;
                bit_nxt    = 3'd0;
                sh_nxt     = next_byte;
                sda_oe_nxt = ~next_byte[7];
              end
            end
            default: ;
          endcase
        end
        B_STOP: begin
          unique case (q)
            2'd0: scl_nxt = 1'b1;
            2'd1: sda_oe_nxt = 1'b0;
            2'd2: begin
              state_nxt = B_IDLE;
              q_nxt     = 2'd0;
              done      = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_nxt = B_IDLE;
      endcase
    end
  end

  assign nack = done & nack_seen;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state     <= B_IDLE;
      q         <= 2'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      sh        <= 8'h00;
      scl_o     <= 1'b1;
      sda_oe    <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      q         <= q_nxt;
      bit_cnt   <= bit_nxt;
      byte_cnt  <= byte_nxt;
      sh        <= sh_nxt;
      scl_o     <= scl_nxt;
      sda_oe    <= sda_oe_nxt;
      nack_seen <= nack_seen_nxt;
    end
  end

endmodule

// File: rtl/amp_init_seq.sv
// Amplifier power-up sequencer: enable, settle, replay the init table over I2C, then hand
// mute to the register bank. Reports busy/done/NACK status back to readable registers.
module amp_init_seq
  import toi2s_pkg::*;
#(
  parameter int                        CLK_DIV    = 60,
  parameter logic [6:0]                AMP_ADDR   = 7'h2C,
  parameter int                        NCMD       = AMP_NCMD,
  parameter int                        EN_WAIT    = 27000,
  parameter amp_cmd_t [NCMD-1:0]       INIT_TABLE = AMP_INIT_TABLE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mute_req,
  input  logic                    sda_i,
  output logic                    scl_o,
  output logic                    sda_oe,
  output logic                    amp_nenable,
  output logic                    amp_mute,
  output logic                    busy,
  output logic                    done,
  output logic                    nack_err,
  output logic [$clog2(NCMD)-1:0] err_idx
);

  localparam int IDX_W  = $clog2(NCMD);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = (EN_WAIT > 1) ? $clog2(EN_WAIT) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EN_WAIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NCMD - 1);

  seq_state_t        state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]  idx;
  logic              q_tick;
  logic              go;
  logic              wr_done, wr_nack;
  amp_cmd_t          cur_cmd;

  assign q_tick  = (div_cnt == DIV_LAST);
  assign cur_cmd = INIT_TABLE[idx];

  // go doubles as the divider clear so every transaction starts on a full quarter.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    unique case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) state_nxt = S_EN_WAIT;
      end
      S_EN_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_XFER;
          go        = 1'b1;
        end
      end
      S_XFER: begin
        if (wr_done) state_nxt = wr_nack ? S_ERROR : S_NEXT;
      end
      S_NEXT: begin
        if (idx == IDX_LAST) begin
          state_nxt = S_RUN;
        end else if (q_tick) begin
          state_nxt = S_XFER;
          go        = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      wait_cnt    <= '0;
      idx         <= '0;
      amp_nenable <= 1'b1;
      amp_mute    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      nack_err    <= 1'b0;
      err_idx     <= '0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= (go || q_tick) ? '0 : div_cnt + 1'b1;
      wait_cnt <= (state == S_EN_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == S_EN_WAIT) begin
        idx <= '0;
      end else if (state == S_NEXT && go) begin
        idx <= idx + 1'b1;
      end
      // Status follows the next state so it lines up with the state change itself.
      amp_nenable <= (state_nxt == S_IDLE) || (state_nxt == S_ERROR);
      amp_mute    <= (state_nxt == S_RUN) ? mute_req : 1'b1;
      busy        <= (state_nxt == S_EN_WAIT) || (state_nxt == S_XFER) || (state_nxt == S_NEXT);
      done        <= (state_nxt == S_RUN);
      nack_err    <= (state_nxt == S_ERROR);
      if (state == S_XFER && state_nxt == S_ERROR) err_idx <= idx;
    end
  end

  amp_i2c_wr u_wr (
    .clk      (clk),
    .reset    (reset),
    .q_tick   (q_tick),
    .go       (go),
    .addr7    (AMP_ADDR),
    .reg_addr (cur_cmd.reg_addr),
    .data     (cur_cmd.data),
    .sda_i    (sda_i),
    .scl_o    (scl_o),
    .sda_oe   (sda_oe),
    .done     (wr_done),
    .nack     (wr_nack)
  );

endmodule

// File: tb/tb_amp_init_seq.sv
// Directed bench for amp_init_seq with a behavioural I2C slave that decodes the bus,
// ACKs (or NACKs a chosen byte) and records timing of START, SCL edges and status changes.
module tb_amp_init_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mute_req;
  logic       sda_i;
  logic       scl_o;
  logic       sda_oe;
  logic       amp_nenable;
  logic       amp_mute;
  logic       busy;
  logic       done;
  logic       nack_err;
  logic [0:0] err_idx;

  always #5 clk = ~clk;

  amp_init_seq #(
    .CLK_DIV    (4),
    .AMP_ADDR   (7'h2C),
    .NCMD       (2),
    .EN_WAIT    (20),
    .INIT_TABLE ({16'h4C30, 16'h0302})
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mute_req    (mute_req),
    .sda_i       (sda_i),
    .scl_o       (scl_o),
    .sda_oe      (sda_oe),
    .amp_nenable (amp_nenable),
    .amp_mute    (amp_mute),
    .busy        (busy),
    .done        (done),
    .nack_err    (nack_err),
    .err_idx     (err_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model and bus monitor ----------------
  logic       ack_drive = 1'b0;
  logic       sda_line;
  assign sda_line = ~(sda_oe | ack_drive);
  assign sda_i    = sda_line;

  int         cyc = 0;
  always @(posedge clk) cyc++;

  logic       mon_clr;
  int         nack_at;
  logic [7:0] rx[$];
  logic [7:0] shreg;
  int         bitn, starts, stops, n_rise, mute_viol, both_chg;
  int         t_nen_fall, t_start, t_done;
  int         rise_t[3];
  logic       scl_prev = 1'b1, sda_prev = 1'b1, nen_prev = 1'b1, done_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      rx.delete();
      bitn = 0; starts = 0; stops = 0; n_rise = 0; mute_viol = 0; both_chg = 0;
      t_nen_fall = -1; t_start = -1; t_done = -1;
      ack_drive = 1'b0;
    end else begin
      if (!amp_nenable && nen_prev) t_nen_fall = cyc;
      if (done && !done_prev) t_done = cyc;
      if (busy && !amp_mute) mute_viol++;
      if (scl_o != scl_prev && sda_line != sda_prev) both_chg++;
      if (scl_o && scl_prev && sda_prev && !sda_line) begin
        starts++;
        if (t_start < 0) t_start = cyc;
        bitn = 0;
      end else if (scl_o && scl_prev && !sda_prev && sda_line) begin
        stops++;
      end else if (scl_o && !scl_prev) begin
        if (n_rise < 3) begin
          rise_t[n_rise] = cyc;
          n_rise++;
        end
        if (bitn < 8) shreg = {shreg[6:0], sda_line};
        bitn++;
        if (bitn == 8) rx.push_back(shreg);
      end else if (!scl_o && scl_prev) begin
        if (bitn == 8) begin
          ack_drive = (nack_at != int'(rx.size()) - 1);
        end else if (bitn == 9) begin
          ack_drive = 1'b0;
          bitn = 0;
        end
      end
    end
    scl_prev  = scl_o;
    sda_prev  = sda_line;
    nen_prev  = amp_nenable;
    done_prev = done;
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] rx_at(input int i);
    if (i < int'(rx.size())) return {24'h0, rx[i]};
    return 32'hDEAD;
  endfunction

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_bytes(input string tag);
    logic [7:0] exp_bytes[6] = '{8'h58, 8'h03, 8'h02, 8'h58, 8'h4C, 8'h30};
    check({tag, "_nbytes"}, rx.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("%s_byte%0d", tag, i), rx_at(i), {24'h0, exp_bytes[i]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; mute_req = 1'b1; nack_at = -1; mon_clr = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0; mon_clr = 1'b0;
    check("rst_scl", scl_o, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_nenable", amp_nenable, 1);
    check("rst_mute", amp_mute, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack_err", nack_err, 0);
    check("rst_err_idx", err_idx, 0);

    // Full init, every byte ACKed, mute requested throughout.
    clear_mon();
    pulse_start();
    check("r1_busy", busy, 1);
    check("r1_nenable", amp_nenable, 0);
    wait_idle(3000, "r1");
    check("r1_start_delay", t_start - t_nen_fall, 20);
    check("r1_scl_period", rise_t[1] - rise_t[0], 16);
    check("r1_done_delay", t_done - t_nen_fall, 20 + 227 * 4 + 1);
    check("r1_done", done, 1);
    check("r1_nack_err", nack_err, 0);
    check("r1_starts", starts, 2);
    check("r1_stops", stops, 2);
    check("r1_mute_viol", mute_viol, 0);
    check("r1_both_chg", both_chg, 0);
    check_bytes("r1");

    // Mute follows mute_req in RUN with one cycle of latency.
    mute_req = 1'b0;
    check("mute_pre_fall", amp_mute, 1);
    @(posedge clk);
    #1 check("mute_fall", amp_mute, 0);
    mute_req = 1'b1;
    check("mute_pre_rise", amp_mute, 0);
    @(posedge clk);
    #1 check("mute_rise", amp_mute, 1);

    // NACK on the data byte of entry 1.
    nack_at = 5;
    clear_mon();
    pulse_start();
    check("r2_done_clr", done, 0);
    check("r2_busy", busy, 1);
    wait_idle(3000, "r2");
    check("r2_nack_err", nack_err, 1);
    check("r2_err_idx", err_idx, 1);
    check("r2_nenable", amp_nenable, 1);
    check("r2_mute", amp_mute, 1);
    check("r2_done", done, 0);
    check("r2_starts", starts, 2);
    check("r2_stops", stops, 2);
    check("r2_nbytes", rx.size(), 6);
    check("r2_byte5", rx_at(5), 32'h30);

    // Restart from ERROR with mute released; a start while busy must be ignored.
    nack_at = -1;
    mute_req = 1'b0;
    clear_mon();
    pulse_start();
    check("r3_nack_clr", nack_err, 0);
    check("r3_busy", busy, 1);
    begin
      int n = 0;
      while (rx.size() < 4 && n < 1500) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("r3_mid_wait", (rx.size() >= 4), 1);
    end
    pulse_start();
    check("r3_busy_after_start", busy, 1);
    wait_idle(3000, "r3");
    check("r3_done_delay", t_done - t_nen_fall, 20 + 227 * 4 + 1);
    check("r3_done", done, 1);
    check("r3_starts", starts, 2);
    check("r3_stops", stops, 2);
    check("r3_mute_viol", mute_viol, 0);
    check("r3_mute_run", amp_mute, 0);
    check("r3_both_chg", both_chg, 0);
    check_bytes("r3");

    // Reset in the middle of a transfer.
    mute_req = 1'b1;
    clear_mon();
    pulse_start();
    repeat (60) @(posedge clk);
    #1;
    begin
      int n = 0;
      while (scl_o && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("r4_pre_reset_scl", scl_o, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("r4_scl", scl_o, 1);
    check("r4_sda_oe", sda_oe, 0);
    check("r4_nenable", amp_nenable, 1);
    check("r4_mute", amp_mute, 1);
    check("r4_busy", busy, 0);
    check("r4_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("r4_idle_busy", busy, 0);
    check("r4_idle_scl", scl_o, 1);
    check("r4_idle_nenable", amp_nenable, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
